// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_pkg
// Purpose  : Shared colour type, scene encodings and default display sizes
// Revision : 1.0 - initial release
// ============================================================================
package lane_pkg;

    typedef logic [11:0] color_t;

    localparam color_t RGB_BLACK = 12'h000;

    typedef enum logic [1:0] {
        SC_START = 2'd0,
        SC_RUN   = 2'd1,
        SC_END   = 2'd2,
        SC_BLANK = 2'd3
    } scene_t;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

endpackage
`default_nettype wire

// File: rtl/lane_compositor_if.sv
`default_nettype none
// ============================================================================
// Module   : lane_compositor_if
// Purpose  : ROM address/data bundle between the compositor and its ROMs
// Revision : 1.0 - initial release
// ============================================================================
interface lane_compositor_if #(
    parameter int N_SPR = 6
);
    logic [18:0]         bg_addr;
    logic [35:0]         bg_rgb;
    logic [13:0]         peo_addr;
    logic [11:0]         peo_rgb;
    logic [N_SPR*14-1:0] spr_addr;
    logic [N_SPR*12-1:0] spr_rgb;

    modport master (
        output bg_addr, peo_addr, spr_addr,
        input  bg_rgb,  peo_rgb,  spr_rgb
    );

    modport slave (
        input  bg_addr, peo_addr, spr_addr,
        output bg_rgb,  peo_rgb,  spr_rgb
    );
endinterface
`default_nettype wire

// File: rtl/sprite_window.sv
`default_nettype none
// ============================================================================
// Module   : sprite_window
// Purpose  : ROM address and window-hit flag for one lane-aligned sprite
// Revision : 1.0 - initial release
// ============================================================================
module sprite_window #(
    parameter int LANE_W = 160,
    parameter int LW     = 2
) (
    input  wire logic [LW-1:0] lane,
    input  wire logic [9:0]    top,
    input  wire logic [9:0]    height,
    input  wire logic          en,
    input  wire logic [8:0]    row,
    input  wire logic [9:0]    col,
    output logic      [13:0]   addr,
    output logic               hit
);
    logic [10:0] w_lane_lo;
    logic [10:0] w_lane_hi;
    logic [10:0] w_bot;

    assign w_lane_lo = 11'(lane) * 11'(LANE_W);
    assign w_lane_hi = w_lane_lo + 11'(LANE_W);
    // 11-bit bottom edge so a top near 1023 cannot wrap into visible rows
    assign w_bot     = {1'b0, top} + {1'b0, height};

    assign hit  = en
               && ({1'b0, row} >= top)
               && ({2'b0, row} <  w_bot)
               && ({1'b0, col} >= w_lane_lo)
               && ({1'b0, col} <  w_lane_hi);

    assign addr = (14'(row) - 14'(top)) * 14'(LANE_W) + 14'(col) - 14'(w_lane_lo);

endmodule
`default_nettype wire

// File: rtl/lane_compositor.sv
`default_nettype none
// ============================================================================
// Module   : lane_compositor
// Purpose  : Frame-shadowed sprite compositor with per-frame collision flag
// Revision : 1.0 - initial release
// ============================================================================
module lane_compositor
    import lane_pkg::*;
#(
    parameter int     N_LANES = 4,
    parameter int     LANE_W  = 160,
    parameter int     N_SPR   = 6,
    parameter int     SPR_H   = 80,
    parameter int     PEO_Y   = 400,
    parameter int     PEO_H   = 80,
    parameter int     H_RES   = DEF_H_RES,
    parameter int     V_RES   = DEF_V_RES,
    parameter color_t KEY     = 12'hFFF,
    localparam int    LW      = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  frame_sync,
    input  wire logic                  rdn,
    input  wire logic [8:0]            row,
    input  wire logic [9:0]            col,
    input  wire logic [N_SPR*LW-1:0]   lanes,
    input  wire logic [N_SPR*10-1:0]   ypos,
    input  wire logic [N_SPR-1:0]      spr_en,
    input  wire logic [LW-1:0]         people,
    input  wire logic [1:0]            scene,
    lane_compositor_if.master          rom,
    output logic      [11:0]           d_in,
    output logic                       collide,
    output logic                       collide_vld
);
    logic [N_SPR*LW-1:0] r_lanes;
    logic [N_SPR*10-1:0] r_ypos;
    logic [N_SPR-1:0]    r_spr_en;
    logic [LW-1:0]       r_people;
    scene_t              r_scene;

    logic [N_SPR-1:0]    r_hit_s1;
    logic                r_peo_hit_s1;
    logic                r_rdn_s1;
    scene_t              r_scene_s1;

    color_t              r_d_in;
    logic                r_collide;
    logic                r_collide_vld;
    logic                r_sticky;
    logic                r_armed;

    logic [N_SPR-1:0]    w_spr_hit;
    logic                w_peo_hit;
    logic [N_SPR*14-1:0] w_spr_addr;
    color_t              w_spr_px;
    logic                w_spr_any;
    logic                w_peo_op;
    color_t              w_px;
    logic                w_hit_now;

    generate
        for (genvar i = 0; i < N_SPR; i++) begin : g_spr
            sprite_window #(.LANE_W(LANE_W), .LW(LW)) u_win (
                .lane   (r_lanes[i*LW +: LW]),
                .top    (r_ypos[i*10 +: 10]),
                .height (10'(SPR_H)),
                .en     (r_spr_en[i]),
                .row    (row),
                .col    (col),
                .addr   (w_spr_addr[i*14 +: 14]),
                .hit    (w_spr_hit[i])
            );
        end
    endgenerate

    sprite_window #(.LANE_W(LANE_W), .LW(LW)) u_peo (
        .lane   (r_people),
        .top    (10'(PEO_Y)),
        .height (10'(PEO_H)),
        .en     (1'b1),
        .row    (row),
        .col    (col),
        .addr   (rom.peo_addr),
        .hit    (w_peo_hit)
    );

    assign rom.spr_addr = w_spr_addr;
    // Background image is stored bottom-up
    assign rom.bg_addr  = rdn ? 19'd0
                        : 19'(10'(V_RES - 1) - {1'b0, row}) * 19'(H_RES) + 19'(col);

    always_comb begin
        w_spr_px  = RGB_BLACK;
        w_spr_any = 1'b0;
        // Walk from the highest index down so the lowest hitting index wins
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (r_hit_s1[i] && (rom.spr_rgb[i*12 +: 12] != KEY)) begin
                w_spr_px  = rom.spr_rgb[i*12 +: 12];
                w_spr_any = 1'b1;
            end
        end
        w_peo_op = r_peo_hit_s1 && (rom.peo_rgb != KEY);
        w_px     = RGB_BLACK;
        if (!r_rdn_s1) begin
            case (r_scene_s1)
                SC_START: w_px = rom.bg_rgb[11:0];
                SC_END:   w_px = rom.bg_rgb[35:24];
                SC_RUN: begin
                    w_px = rom.bg_rgb[23:12];
                    if (w_spr_any) w_px = w_spr_px;
                    if (w_peo_op)  w_px = rom.peo_rgb;
                end
                default:  w_px = RGB_BLACK;
            endcase
        end
        w_hit_now = (r_scene_s1 == SC_RUN) && w_spr_any && w_peo_op;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lanes       <= '0;
            r_ypos        <= '0;
            r_spr_en      <= '0;
            r_people      <= '0;
            r_scene       <= SC_START;
            r_hit_s1      <= '0;
            r_peo_hit_s1  <= 1'b0;
            r_rdn_s1      <= 1'b0;
            r_scene_s1    <= SC_START;
            r_d_in        <= RGB_BLACK;
            r_collide     <= 1'b0;
            r_collide_vld <= 1'b0;
            r_sticky      <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_hit_s1     <= w_spr_hit;
            r_peo_hit_s1 <= w_peo_hit;
            r_rdn_s1     <= rdn;
            r_scene_s1   <= r_scene;
            r_d_in       <= w_px;
            if (frame_sync) begin
                r_lanes  <= lanes;
                r_ypos   <= ypos;
                r_spr_en <= spr_en;
                r_people <= people;
                r_scene  <= scene_t'(scene);
                r_sticky <= 1'b0;
                r_armed  <= 1'b1;
                // The first sync after reset closes a partial frame: no report
                if (r_armed) begin
                    r_collide     <= r_sticky | w_hit_now;
                    r_collide_vld <= 1'b1;
                end else begin
                    r_collide_vld <= 1'b0;
                end
            end else begin
                r_collide_vld <= 1'b0;
                if (w_hit_now) r_sticky <= 1'b1;
            end
        end
    end

    assign d_in        = r_d_in;
    assign collide     = r_collide;
    assign collide_vld = r_collide_vld;

endmodule
`default_nettype wire
